// File: rtl/seven_seg_pkg.sv
// Shared constants and glyph decode for the seven-segment scanner.
// Latency: purely combinational helpers, no state.
// Backpressure: none; constants and functions only.
package seven_seg_pkg;

    // Segment bit positions within the 8-bit segment bus
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Logical "nothing lit" values, before pin polarity is applied
    localparam logic [7:0] SEG_ALL_OFF = 8'h00;
    localparam logic       DIG_OFF     = 1'b0;

    // Hex nibble to segments, bit order g..a (bit 6 = g, bit 0 = a), active-high
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Slot prescaler, digit index counter, frame wrap strobe and PWM lit-window compare.
// Latency: index/prescaler are registers; wrap and lit are combinational from them.
// Backpressure: free-running, never stalls.
module seven_seg_scan_timer #(
    parameter int SCAN_DIVISOR    = 50000,
    parameter int NUM_DIGITS      = 4,
    parameter int BLANK_TICKS     = 1,
    parameter int BRIGHTNESS_BITS = 4,
    localparam int PS_W  = $clog2(SCAN_DIVISOR),
    localparam int IDX_W = $clog2(NUM_DIGITS)
) (
    input  logic                       clock,
    input  logic                       notReset,
    input  logic [BRIGHTNESS_BITS-1:0] brightness,
    output logic [IDX_W-1:0]           index,
    output logic                       wrap,
    output logic                       lit
);

    logic [PS_W-1:0] prescaler;
    logic            terminal;
    logic            last_digit;
    logic [31:0]     on_ticks;

    assign terminal   = (prescaler == PS_W'(SCAN_DIVISOR - 1));
    assign last_digit = (index == IDX_W'(NUM_DIGITS - 1));
    assign wrap       = terminal && last_digit;

    // Lit window: blanking guard at slot start, PWM cut-off from the live brightness
    always_comb begin
        on_ticks = ((32'(brightness) + 32'd1) * 32'(SCAN_DIVISOR)) >> BRIGHTNESS_BITS;
        lit      = (32'(prescaler) >= 32'(BLANK_TICKS)) && (32'(prescaler) < on_ticks);
    end

    // Prescaler counts one slot; index advances at each slot end and wraps per frame
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            prescaler <= '0;
            index     <= '0;
        end else if (terminal) begin
            prescaler <= '0;
            index     <= last_digit ? '0 : index + IDX_W'(1);
        end else begin
            prescaler <= prescaler + PS_W'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed 7-segment driver: double-buffered digits, zero blanking, PWM, polarity.
// Latency: pins lag internal scan state by 1 cycle; load shows at the next frame wrap.
// Backpressure: none; load always accepted, latest pending value wins.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS         = 4,
    parameter int SCAN_DIVISOR       = 50000,
    parameter int BLANK_TICKS        = 1,
    parameter int BRIGHTNESS_BITS    = 4,
    parameter int SEGMENT_ACTIVE_LOW = 1,
    parameter int DIGIT_ACTIVE_LOW   = 1
) (
    input  logic                       clock,
    input  logic                       notReset,
    input  logic [4*NUM_DIGITS-1:0]    data,
    input  logic [NUM_DIGITS-1:0]      decimalPoints,
    input  logic                       load,
    input  logic                       blankLeadingZeros,
    input  logic [BRIGHTNESS_BITS-1:0] brightness,
    output logic [7:0]                 segment,
    output logic [NUM_DIGITS-1:0]      digit,
    output logic                       frameStart
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [7:0] SEG_MASK = (SEGMENT_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_MASK =
        (DIGIT_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [IDX_W-1:0] index;
    logic             wrap;
    logic             lit;

    logic [4*NUM_DIGITS-1:0] pend_data, act_data;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
    logic                    pend_blz, act_blz;
    logic                    pend_vld;

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  zero_run;
    logic [7:0]            seg_logic;
    logic [NUM_DIGITS-1:0] dig_logic;

    seven_seg_scan_timer #(
        .SCAN_DIVISOR    (SCAN_DIVISOR),
        .NUM_DIGITS      (NUM_DIGITS),
        .BLANK_TICKS     (BLANK_TICKS),
        .BRIGHTNESS_BITS (BRIGHTNESS_BITS)
    ) u_timer (
        .clock      (clock),
        .notReset   (notReset),
        .brightness (brightness),
        .index      (index),
        .wrap       (wrap),
        .lit        (lit)
    );

    // Double buffer: active only changes at a frame wrap, so a frame is never torn
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            pend_data <= '0;
            pend_dp   <= '0;
            pend_blz  <= 1'b0;
            pend_vld  <= 1'b0;
            act_data  <= '0;
            act_dp    <= '0;
            act_blz   <= 1'b0;
        end else if (wrap) begin
            // A load landing on the wrap bypasses pending and takes effect this frame
            if (load) begin
                act_data <= data;
                act_dp   <= decimalPoints;
                act_blz  <= blankLeadingZeros;
            end else if (pend_vld) begin
                act_data <= pend_data;
                act_dp   <= pend_dp;
                act_blz  <= pend_blz;
            end
            pend_vld <= 1'b0;
        end else if (load) begin
            pend_data <= data;
            pend_dp   <= decimalPoints;
            pend_blz  <= blankLeadingZeros;
            pend_vld  <= 1'b1;
        end
    end

    // Select current digit, compute leading-zero run from the top, build logical outputs
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        zero_run  = 1'b1;
        blank_vec = '0;
        dig_logic = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run && (act_data[4*k +: 4] == 4'h0) && !act_dp[k];
            blank_vec[k] = act_blz && zero_run && (k != 0);
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (index == IDX_W'(k)) begin
                cur_nib      = act_data[4*k +: 4];
                cur_dp       = act_dp[k];
                cur_blank    = blank_vec[k];
                dig_logic[k] = lit;
            end
        end
        seg_logic = cur_blank ? SEG_ALL_OFF : {cur_dp, hex_to_seg(cur_nib)};
    end

    // Output registers; polarity applied only here so reset is "off" at the pins
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            segment    <= SEG_ALL_OFF ^ SEG_MASK;
            digit      <= {NUM_DIGITS{DIG_OFF}} ^ DIG_MASK;
            frameStart <= 1'b0;
        end else begin
            segment    <= seg_logic ^ SEG_MASK;
            digit      <= dig_logic ^ DIG_MASK;
            frameStart <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with a cycle-count based reference model.
// Latency: model predicts pins one cycle after the scan position it derives.
// Backpressure: n/a.
module tb_seven_seg_scanner;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int BT = 1;
    localparam int BB = 2;
    localparam int FRAME = N * SD;

    // Standard hex glyphs, bit 6 = g .. bit 0 = a
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clock = 1'b0;
    logic        notReset = 1'b1;
    logic [15:0] data = 16'h0;
    logic [3:0]  decimalPoints = 4'h0;
    logic        load = 1'b0;
    logic        blankLeadingZeros = 1'b0;
    logic [1:0]  brightness = 2'd3;
    logic [7:0]  segment;
    logic [3:0]  digit;
    logic        frameStart;

    int errors = 0;
    int checks = 0;
    bit run_en = 1'b0;

    seven_seg_scanner #(
        .NUM_DIGITS         (N),
        .SCAN_DIVISOR       (SD),
        .BLANK_TICKS        (BT),
        .BRIGHTNESS_BITS    (BB),
        .SEGMENT_ACTIVE_LOW (1),
        .DIGIT_ACTIVE_LOW   (1)
    ) dut (
        .clock             (clock),
        .notReset          (notReset),
        .data              (data),
        .decimalPoints     (decimalPoints),
        .load              (load),
        .blankLeadingZeros (blankLeadingZeros),
        .brightness        (brightness),
        .segment           (segment),
        .digit             (digit),
        .frameStart        (frameStart)
    );

    always #5 clock = ~clock;

    // Reference model: cycles since reset release determine slot, digit and wrap
    int          cnt = 0;
    logic [15:0] m_act_d = 16'h0, m_pend_d = 16'h0;
    logic [3:0]  m_act_dp = 4'h0, m_pend_dp = 4'h0;
    logic        m_act_b = 1'b0, m_pend_b = 1'b0, m_pv = 1'b0;
    logic [7:0]  exp_seg = 8'hFF;
    logic [3:0]  exp_dig = 4'hF;
    logic        exp_fs = 1'b0;
    int          m_ps, m_idx, m_on;
    logic [15:0] m_upper;
    logic [3:0]  m_dpu;
    logic        m_wrap;

    initial begin
        forever begin
            @(posedge clock or negedge notReset);
            if (!notReset) begin
                cnt = 0;
                m_act_d = 16'h0; m_act_dp = 4'h0; m_act_b = 1'b0;
                m_pend_d = 16'h0; m_pend_dp = 4'h0; m_pend_b = 1'b0; m_pv = 1'b0;
                exp_seg = 8'hFF; exp_dig = 4'hF; exp_fs = 1'b0;
            end else begin
                m_ps  = cnt % SD;
                m_idx = (cnt / SD) % N;
                m_on  = ((int'(brightness) + 1) * SD) >> BB;
                exp_dig = (m_ps >= BT && m_ps < m_on) ? ~(4'b0001 << m_idx) : 4'hF;
                m_upper = m_act_d >> (4 * m_idx);
                m_dpu   = m_act_dp >> m_idx;
                if (m_act_b && m_idx != 0 && m_upper == 16'h0 && m_dpu == 4'h0)
                    exp_seg = 8'hFF;
                else
                    exp_seg = ~{m_act_dp[m_idx], GLYPH[m_act_d[4*m_idx +: 4]]};
                m_wrap = (cnt % FRAME) == FRAME - 1;
                exp_fs = m_wrap;
                if (m_wrap) begin
                    if (load) begin
                        m_act_d = data; m_act_dp = decimalPoints; m_act_b = blankLeadingZeros;
                    end else if (m_pv) begin
                        m_act_d = m_pend_d; m_act_dp = m_pend_dp; m_act_b = m_pend_b;
                    end
                    m_pv = 1'b0;
                end else if (load) begin
                    m_pend_d = data; m_pend_dp = decimalPoints; m_pend_b = blankLeadingZeros;
                    m_pv = 1'b1;
                end
                cnt = cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at t=%0t cnt=%0d: got %h, expected %h", name, $time, cnt, act, expv);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (run_en) begin
            chk("model_segment", 32'(segment), 32'(exp_seg));
            chk("model_digit", 32'(digit), 32'(exp_dig));
            chk("model_frameStart", 32'(frameStart), 32'(exp_fs));
        end
    end

    task automatic wait_cnt(input int target);
        int n = 0;
        while (cnt != target && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (cnt != target) begin
            checks++;
            errors++;
            $display("FAIL wait_cnt: reached %0d, required %0d", cnt, target);
        end
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] dp, input logic blz);
        data = d;
        decimalPoints = dp;
        blankLeadingZeros = blz;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic pin(input string name, input logic [7:0] s, input logic [3:0] d);
        chk({name, "_seg"}, 32'(segment), 32'(s));
        chk({name, "_dig"}, 32'(digit), 32'(d));
    endtask

    int lit_cnt;
    int fs_cnt;

    initial begin
        #1 notReset = 1'b0;
        run_en = 1'b1;
        repeat (3) @(negedge clock);
        pin("reset", 8'hFF, 4'hF);
        chk("reset_fs", 32'(frameStart), 32'd0);
        notReset = 1'b1;

        // First lit cycle is BLANK_TICKS+1 after release; active buffer is zero
        wait_cnt(1);  pin("first_blank", 8'hC0, 4'hF);
        wait_cnt(2);  pin("first_lit", 8'hC0, 4'hE);

        wait_cnt(3);  pulse_load(16'h12AF, 4'h0, 1'b0);
        wait_cnt(32); chk("wrap_fs", 32'(frameStart), 32'd1);
        wait_cnt(33); pin("F_ps0", 8'h8E, 4'hF);
        wait_cnt(34); pin("F_ps1", 8'h8E, 4'hE);
        wait_cnt(58); pin("one_d3", 8'hF9, 4'h7);

        // PWM duty: brightness 0 -> 1 lit cycle per slot, 1 -> 3 cycles
        wait_cnt(64);
        brightness = 2'd0;
        lit_cnt = 0;
        repeat (32) begin @(negedge clock); if (digit != 4'hF) lit_cnt++; end
        chk("lit_b0", 32'(lit_cnt), 32'd4);
        brightness = 2'd1;
        lit_cnt = 0;
        repeat (32) begin @(negedge clock); if (digit != 4'hF) lit_cnt++; end
        chk("lit_b1", 32'(lit_cnt), 32'd12);
        brightness = 2'd3;

        // Two loads mid-frame: old value held until wrap, then latest wins
        wait_cnt(130); pulse_load(16'h0000, 4'h0, 1'b0);
        wait_cnt(140); pulse_load(16'h0042, 4'h0, 1'b0);
        wait_cnt(154); pin("hold_old_d3", 8'hF9, 4'h7);
        wait_cnt(162); pin("new_d0", 8'hA4, 4'hE);
        wait_cnt(170); pin("new_d1", 8'h99, 4'hD);
        wait_cnt(186); pin("new_d3", 8'hC0, 4'h7);

        fs_cnt = 0;
        repeat (64) begin @(negedge clock); if (frameStart) fs_cnt++; end
        chk("fs_period", 32'(fs_cnt), 32'd2);

        // Leading-zero blanking, then a decimal point unblanks digit 2
        wait_cnt(252); pulse_load(16'h0040, 4'h0, 1'b1);
        wait_cnt(290); pin("blz_d0", 8'hC0, 4'hE);
        wait_cnt(298); pin("blz_d1", 8'h99, 4'hD);
        wait_cnt(306); pin("blz_d2", 8'hFF, 4'hB);
        wait_cnt(314); pin("blz_d3", 8'hFF, 4'h7);
        wait_cnt(320); pulse_load(16'h0040, 4'b0100, 1'b1);
        wait_cnt(370); pin("dp_d2", 8'h40, 4'hB);
        wait_cnt(378); pin("dp_d3", 8'hFF, 4'h7);

        // Load on the wrap cycle goes straight to active and clears pending
        wait_cnt(390); pulse_load(16'h1234, 4'h0, 1'b0);
        wait_cnt(415); pulse_load(16'h5678, 4'h0, 1'b0);
        wait_cnt(418); pin("coinc_d0", 8'h80, 4'hE);
        wait_cnt(450); pin("coinc_next_d0", 8'h80, 4'hE);

        // Asynchronous reset mid-slot
        wait_cnt(460);
        #2 notReset = 1'b0;
        #1 pin("async_rst", 8'hFF, 4'hF);
        chk("async_rst_fs", 32'(frameStart), 32'd0);
        @(negedge clock);
        notReset = 1'b1;
        wait_cnt(2);  pin("restart_d0", 8'hC0, 4'hE);
        wait_cnt(10); pin("restart_d1", 8'hC0, 4'hD);
        wait_cnt(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised time-multiplexed 7-segment display driver for devboard debug output, generalising the fixed 4-digit scanner. It sits between a core MMIO output port and the board's segment/digit pins. It adds:
- configurable digit count and scan rate;
- double-buffered (tear-free) updates;
- leading-zero blanking;
- PWM brightness;
- anti-ghosting blanking at each digit switch.

## Interface
- NUM_DIGITS, 4, number of digits scanned (≥2)
- SCAN_DIVISOR, 50000, clock cycles per digit slot (1 kHz slot rate at 50 MHz); must be ≥ 2^BRIGHTNESS_BITS
- BLANK_TICKS, 1, cycles at start of each slot with all digits off; must be < SCAN_DIVISOR >> BRIGHTNESS_BITS
- BRIGHTNESS_BITS, 4, width of brightness input
- SEGMENT_ACTIVE_LOW, 1, segment pin polarity
- DIGIT_ACTIVE_LOW, 1, digit pin polarity

Ports:
- clock  in  1  system clock
- notReset  in  1  asynchronous, active-low reset
- data  in  4*NUM_DIGITS  hex nibbles; data[3:0] is digit 0, the rightmost and least significant
- decimalPoints  in  NUM_DIGITS  DP enable per digit
- load  in  1  capture data/decimalPoints/blankLeadingZeros into the pending buffer
- blankLeadingZeros  in  1  enable leading-zero suppression (captured with load)
- brightness  in  BRIGHTNESS_BITS  duty level, sampled live; max = full on
- segment  out  8  [7]=DP, [6:0]=g..a, registered
- digit  out  NUM_DIGITS  one-hot digit enable, registered
- frameStart  out  1  one-cycle pulse when scan index wraps to 0

## Operation
**Scan timer**
- Prescaler counts 0..SCAN_DIVISOR-1 and wraps.
- At terminal count, the index advances 0→1→…→NUM_DIGITS-1→0.

**Buffering**
- load writes the pending buffer and sets pendingValid. Repeated loads overwrite it; the latest wins.
- On index wrap to 0, if pendingValid: active ← pending and pendingValid clears.
- load in the same cycle as the wrap: the new data goes straight to active and pendingValid stays 0.

**Lit window**
- onTicks = ((brightness+1) × SCAN_DIVISOR) >> BRIGHTNESS_BITS.
- The current digit's enable is asserted only while BLANK_TICKS ≤ prescaler < onTicks. Otherwise all digits are off.

**Segments**
- Segments show the hex decode (0–F, standard glyphs) of the active nibble for the current index.
- segment[7] is set from active decimalPoints[index].

**Blanking**
- With active blankLeadingZeros=1, digit k is blanked (segments all off, digit enable still follows PWM) when nibbles k..NUM_DIGITS-1 are all zero and decimalPoints k..NUM_DIGITS-1 are all zero.
- Digit 0 is never blanked.

**Polarity and reset**
- Polarity parameters invert the final registered outputs only.
- Reset, asynchronous: prescaler=0, index=0, active/pending buffers=0, pendingValid=0, frameStart=0.
- Reset values of segment and digit are all inactive at their configured polarity.

## Timing
- Outputs are registered, so pins lag the internal prescaler/index by one cycle.
- First lit cycle after reset release: cycle BLANK_TICKS+1.
- frameStart asserts in the cycle after the index changes to 0. Period = NUM_DIGITS × SCAN_DIVISOR.
- Data latency from load to display: ≤ NUM_DIGITS × SCAN_DIVISOR + 1 cycles. A display update never occurs mid-frame.
- brightness changes take effect the next cycle, with no glitch beyond the window boundary shift.
- Reset asserted mid-slot forces all outputs inactive immediately, without waiting for a clock edge.

## Structure
- Package seven_seg_pkg holds:
  - the hex-to-segment function (g..a order);
  - the segment bit index constants (SEG_DP=7);
  - the all-off constants.
- Sub-module seven_seg_scan_timer contains the prescaler, index counter, wrap strobe and lit-window compare; it is parametrised by SCAN_DIVISOR, NUM_DIGITS, BLANK_TICKS, BRIGHTNESS_BITS.
- The top module holds the buffers, blanking logic, decode and output registers.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIVISOR=8, BLANK_TICKS=1, BRIGHTNESS_BITS=2, both polarities active-low.
- Reset, then release, brightness=3, load data=16'h12AF → after the first frame, the digit 0 slot shows segment=~8'h71 ("F"), digit=4'b1110 for prescaler 1..7 and 4'b1111 at prescaler 0; digits 3..0 show 1,2,A,F.
- brightness=0 → each digit lit exactly 1 cycle per 8-cycle slot (prescaler=1). brightness=1 → lit 3 cycles (prescaler 1..3).
- Load 16'h0000 then 16'h0042 mid-frame → display keeps old value until wrap, then shows 42. frameStart pulses every 32 cycles.
- blankLeadingZeros=1 with data 16'h0040 → digits 3,2 segments all off, digits 1,0 show "4","0". Adding decimalPoints=4'b0100 → digit 2 shows "0." and is unblanked.
- Load coincident with wrap → new value appears in that frame; pendingValid=0 afterwards.
- Assert notReset=0 mid-slot → segment=8'hFF and digit=4'hF within the same cycle; the scan restarts at index 0 after release.
